wb_stage_reg: RTL and testbench

//  MEM/WB pipeline register feeding the 4:1 write-back mux. Captures ALU result, load data, immediate
//  and write-back select from MEM; aligns/extends load data, forms LI/LUI values, drives the mux inputs
//  and select one cycle later. Handles stall, flush, bubbles; counts retired register writes.

---
 rtl/wb_stage_reg.sv | 137 +++++++++++++
 tb/tb_wb_stage_reg.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_reg.sv
// MEM/WB pipeline register feeding the 4:1 write-back mux.
// Captures ALU result, aligned/extended load data, LI and LUI values, the
// write-back select and destination register, and counts retired writes.
// Optional feature macro: MISALIGN_TRAP_EN adds the misalign_err output and
// suppresses the register write for misaligned half/word loads.
module wb_stage_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int IMM_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] alu_res,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [IMM_W-1:0]      imm,
  input  logic [1:0]            addr_lo,
  input  logic [1:0]            ld_size,
  input  logic                  ld_unsigned,
  input  logic [1:0]            wb_sel,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  reg_we,
  output logic [DATA_WIDTH-1:0] mux_in0,
  output logic [DATA_WIDTH-1:0] mux_in1,
  output logic [DATA_WIDTH-1:0] mux_in2,
  output logic [DATA_WIDTH-1:0] mux_in3,
  output logic [1:0]            mux_sel,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_we,
  output logic                  out_valid,
`ifdef MISALIGN_TRAP_EN
  output logic                  misalign_err,
`endif
  output logic [31:0]           retire_cnt
);

  logic [DATA_WIDTH-1:0] aluRes_q, loadData_q, liVal_q, luiVal_q;
  logic [DATA_WIDTH-1:0] loadData_d, liVal_d, luiVal_d;
  logic [1:0]            muxSel_q;
  logic [REG_ADDR_W-1:0] wbRd_q;
  logic                  wbWe_q, wbWe_d;
  logic                  outValid_q;
  logic [31:0]           retireCnt_q;
  logic [7:0]            byteLane;
  logic [15:0]           halfLane;
  logic                  misalign_d;
`ifdef MISALIGN_TRAP_EN
  logic                  misalign_q;
`endif

  // Select the addressed byte/half lane of the read word and extend it to full width.
  always_comb begin
    byteLane   = mem_rdata[7:0];
    halfLane   = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    loadData_d = mem_rdata;
    case (addr_lo)
      2'd0:    byteLane = mem_rdata[7:0];
      2'd1:    byteLane = mem_rdata[15:8];
      2'd2:    byteLane = mem_rdata[23:16];
      default: byteLane = mem_rdata[31:24];
    endcase
    case (ld_size)
      2'b10:   loadData_d = ld_unsigned ? {{(DATA_WIDTH-8){1'b0}}, byteLane}
                                        : {{(DATA_WIDTH-8){byteLane[7]}}, byteLane};
      2'b01:   loadData_d = ld_unsigned ? {{(DATA_WIDTH-16){1'b0}}, halfLane}
                                        : {{(DATA_WIDTH-16){halfLane[15]}}, halfLane};
      default: loadData_d = mem_rdata;
    endcase
  end

  // Form immediate values, detect misaligned loads and decide the register write enable.
  always_comb begin
    liVal_d    = {{(DATA_WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
    luiVal_d   = {imm, {IMM_W{1'b0}}};
    misalign_d = in_valid && (wb_sel == 2'b01) &&
                 (((ld_size == 2'b01) && addr_lo[0]) ||
                  (((ld_size == 2'b00) || (ld_size == 2'b11)) && (addr_lo != 2'b00)));
`ifdef MISALIGN_TRAP_EN
    wbWe_d     = in_valid && reg_we && (rd_addr != '0) && !misalign_d;
`else
    wbWe_d     = in_valid && reg_we && (rd_addr != '0) && !(misalign_d && 1'b0);
`endif
  end

  // Pipeline register: flush kills the instruction, stall freezes everything, otherwise load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluRes_q    <= '0;
      loadData_q  <= '0;
      liVal_q     <= '0;
      luiVal_q    <= '0;
      muxSel_q    <= '0;
      wbRd_q      <= '0;
      wbWe_q      <= 1'b0;
      outValid_q  <= 1'b0;
      retireCnt_q <= '0;
`ifdef MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else if (flush) begin
      wbWe_q      <= 1'b0;
      outValid_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else if (!stall) begin
      aluRes_q    <= alu_res;
      loadData_q  <= loadData_d;
      liVal_q     <= liVal_d;
      luiVal_q    <= luiVal_d;
      muxSel_q    <= wb_sel;
      wbRd_q      <= rd_addr;
      wbWe_q      <= wbWe_d;
      outValid_q  <= in_valid;
      if (wbWe_q) retireCnt_q <= retireCnt_q + 32'd1;
`ifdef MISALIGN_TRAP_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  assign mux_in0    = aluRes_q;
  assign mux_in1    = loadData_q;
  assign mux_in2    = liVal_q;
  assign mux_in3    = luiVal_q;
  assign mux_sel    = muxSel_q;
  assign wb_rd      = wbRd_q;
  assign wb_we      = wbWe_q;
  assign out_valid  = outValid_q;
  assign retire_cnt = retireCnt_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign_err = misalign_q;
`endif

endmodule

// File: tb/tb_wb_stage_reg.sv
// Self-checking bench for wb_stage_reg: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_wb_stage_reg;

  logic        clk, rst_n;
  logic        in_valid, stall, flush, ld_unsigned, reg_we;
  logic [31:0] alu_res, mem_rdata;
  logic [15:0] imm;
  logic [1:0]  addr_lo, ld_size, wb_sel;
  logic [4:0]  rd_addr;
  logic [31:0] mux_in0, mux_in1, mux_in2, mux_in3, retire_cnt;
  logic [1:0]  mux_sel;
  logic [4:0]  wb_rd;
  logic        wb_we, out_valid;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: what the write-back stage should present.
  logic [31:0] expIn0, expIn1, expIn2, expIn3, expCnt;
  logic [1:0]  expSel;
  logic [4:0]  expRd;
  logic        expWe, expValid, expMis;
  logic [31:0] cntSnap;

  wb_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_res(alu_res), .mem_rdata(mem_rdata), .imm(imm), .addr_lo(addr_lo),
    .ld_size(ld_size), .ld_unsigned(ld_unsigned), .wb_sel(wb_sel),
    .rd_addr(rd_addr), .reg_we(reg_we),
    .mux_in0(mux_in0), .mux_in1(mux_in1), .mux_in2(mux_in2), .mux_in3(mux_in3),
    .mux_sel(mux_sel), .wb_rd(wb_rd), .wb_we(wb_we), .out_valid(out_valid),
`ifdef MISALIGN_TRAP_EN
    .misalign_err(misalign_err),
`endif
    .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected load value computed arithmetically from the lane rules.
  function automatic logic [31:0] refLoad(logic [31:0] rdata, int addr, int size, bit uns);
    logic [31:0] v;
    if (size == 2) begin
      v = (rdata >> (8 * addr)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v | 32'hFFFFFF00;
    end else if (size == 1) begin
      v = (rdata >> ((addr >= 2) ? 16 : 0)) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v | 32'hFFFF0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  function automatic bit refMisaligned(bit valid, int sel, int size, int addr);
`ifdef MISALIGN_TRAP_EN
    return valid && sel == 1 &&
           ((size == 1 && (addr % 2) == 1) || ((size == 0 || size == 3) && addr != 0));
`else
    return 1'b0;
`endif
  endfunction

  task automatic resetModel();
    expIn0 = 0; expIn1 = 0; expIn2 = 0; expIn3 = 0; expCnt = 0;
    expSel = 0; expRd = 0; expWe = 0; expValid = 0; expMis = 0;
  endtask

  // Advance one clock edge and update the reference model with the inputs that edge sampled.
  task automatic applyStimulus();
    bit mis;
    @(posedge clk);
    #1;
    mis = refMisaligned(in_valid, wb_sel, ld_size, addr_lo);
    if (flush) begin
      expValid = 0;
      expWe    = 0;
      expMis   = 0;
    end else if (!stall) begin
      if (expWe) expCnt = expCnt + 1;
      expIn0   = alu_res;
      expIn1   = refLoad(mem_rdata, addr_lo, ld_size, ld_unsigned);
      expIn2   = (imm >= 16'h8000) ? (32'hFFFF0000 + imm) : {16'h0, imm};
      expIn3   = imm * 32'h10000;
      expSel   = wb_sel;
      expRd    = rd_addr;
      expValid = in_valid;
      expWe    = in_valid && reg_we && rd_addr != 0 && !mis;
      expMis   = mis;
    end
  endtask

  task automatic checkVal(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(string step);
    checkVal({step, ".mux_in0"}, mux_in0, expIn0);
    checkVal({step, ".mux_in1"}, mux_in1, expIn1);
    checkVal({step, ".mux_in2"}, mux_in2, expIn2);
    checkVal({step, ".mux_in3"}, mux_in3, expIn3);
    checkVal({step, ".mux_sel"}, {30'b0, mux_sel}, {30'b0, expSel});
    checkVal({step, ".wb_rd"}, {27'b0, wb_rd}, {27'b0, expRd});
    checkVal({step, ".wb_we"}, {31'b0, wb_we}, {31'b0, expWe});
    checkVal({step, ".out_valid"}, {31'b0, out_valid}, {31'b0, expValid});
    checkVal({step, ".retire_cnt"}, retire_cnt, expCnt);
`ifdef MISALIGN_TRAP_EN
    checkVal({step, ".misalign_err"}, {31'b0, misalign_err}, {31'b0, expMis});
`endif
  endtask

  task automatic setLoad(logic [4:0] rd, logic [31:0] rdata, logic [1:0] size,
                         logic [1:0] addr, logic uns);
    in_valid = 1; stall = 0; flush = 0; reg_we = 1; wb_sel = 2'b01;
    rd_addr = rd; mem_rdata = rdata; ld_size = size; addr_lo = addr; ld_unsigned = uns;
  endtask

  initial begin
    $display("[TB] wb_stage_reg bench starting");
    rst_n = 0; in_valid = 0; stall = 0; flush = 0; ld_unsigned = 0; reg_we = 0;
    alu_res = 0; mem_rdata = 0; imm = 0; addr_lo = 0; ld_size = 0; wb_sel = 0; rd_addr = 0;
    resetModel();
    repeat (2) @(posedge clk);
    #1 checkOutput("reset");
    @(negedge clk) rst_n = 1;

    // Async reset in the middle of a cycle while a write is pending.
    in_valid = 1; reg_we = 1; rd_addr = 3; alu_res = 32'h1234_5678; imm = 16'h0042;
    applyStimulus();
    applyStimulus();
    checkOutput("preReset");
    checkVal("preReset.weHigh", {31'b0, wb_we}, 32'd1);
    #2 rst_n = 0;
    #1 resetModel();
    checkOutput("midReset");
    @(negedge clk) rst_n = 1;
    in_valid = 0;
    applyStimulus();
    checkVal("afterReset.retire", retire_cnt, 32'd0);

    // Byte and half load alignment and extension.
    setLoad(5'd4, 32'h80FF7F01, 2'b10, 2'd3, 1'b0);
    applyStimulus(); checkOutput("byteSigned");
    checkVal("byteSigned.val", mux_in1, 32'hFFFFFF80);
    ld_unsigned = 1;
    applyStimulus(); checkOutput("byteUnsigned");
    checkVal("byteUnsigned.val", mux_in1, 32'h00000080);
    ld_size = 2'b01; addr_lo = 2'd2; ld_unsigned = 0;
    applyStimulus(); checkOutput("halfSigned");
    checkVal("halfSigned.val", mux_in1, 32'hFFFF80FF);

    // LI / LUI immediate forms and select tracking.
    imm = 16'h8001; wb_sel = 2'b10;
    applyStimulus(); checkOutput("immediate");
    checkVal("immediate.li", mux_in2, 32'hFFFF8001);
    checkVal("immediate.lui", mux_in3, 32'h80010000);
    checkVal("immediate.sel", {30'b0, mux_sel}, 32'd2);

    // Valid write to r5 followed by a three-cycle stall.
    rd_addr = 5; wb_sel = 2'b00; alu_res = 32'hCAFE_0005;
    applyStimulus(); checkOutput("writeR5");
    cntSnap = expCnt;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      alu_res = $urandom; imm = 16'($urandom); rd_addr = 5'($urandom);
      applyStimulus(); checkOutput("stallHold");
      checkVal("stallHold.rd", {27'b0, wb_rd}, 32'd5);
    end
    stall = 0; in_valid = 0;
    applyStimulus(); checkOutput("stallRelease");
    checkVal("stallRelease.retire", retire_cnt, cntSnap + 32'd1);

    // Flush wins over stall, then a write to r0 stays silent.
    in_valid = 1; reg_we = 1; rd_addr = 7; flush = 1; stall = 1;
    applyStimulus(); checkOutput("flushStall");
    checkVal("flushStall.valid", {31'b0, out_valid}, 32'd0);
    flush = 0; stall = 0; rd_addr = 0;
    applyStimulus(); checkOutput("writeR0");
    checkVal("writeR0.we", {31'b0, wb_we}, 32'd0);
    checkVal("writeR0.valid", {31'b0, out_valid}, 32'd1);

    // Misaligned word load.
    setLoad(5'd9, 32'hA5A5_1234, 2'b00, 2'd2, 1'b0);
    applyStimulus(); checkOutput("misalignWord");
    checkVal("misalignWord.data", mux_in1, 32'hA5A5_1234);
`ifdef MISALIGN_TRAP_EN
    checkVal("misalignWord.err", {31'b0, misalign_err}, 32'd1);
    checkVal("misalignWord.we", {31'b0, wb_we}, 32'd0);
`else
    checkVal("misalignWord.we", {31'b0, wb_we}, 32'd1);
`endif

    // Random traffic with occasional stalls, flushes and asynchronous resets.
    for (int n = 0; n < 400; n++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      stall       = ($urandom_range(0, 4) == 0);
      flush       = ($urandom_range(0, 7) == 0);
      alu_res     = $urandom;
      mem_rdata   = $urandom;
      imm         = 16'($urandom);
      addr_lo     = 2'($urandom);
      ld_size     = 2'($urandom);
      ld_unsigned = 1'($urandom);
      wb_sel      = 2'($urandom);
      rd_addr     = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      reg_we      = ($urandom_range(0, 4) != 0);
      applyStimulus();
      checkOutput("random");
      if ($urandom_range(0, 99) == 0) begin
        #2 rst_n = 0;
        #1 resetModel();
        checkOutput("randomReset");
        @(negedge clk) rst_n = 1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
